// File: rtl/soc_system_pll_audio_pkg.sv
// Shared types and default timing constants for the audio PLL supervisor.
package soc_system_pll_audio_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 1000000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/soc_system_pll_audio_sync.sv
// Two-flop synchronizer bringing the PLL lock flag into the refclk domain.
module soc_system_pll_audio_sync (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/soc_system_pll_audio_supervisor.sv
// Audio PLL bring-up supervisor: reset pulse, lock wait with retries, stability filter.
// Define SOC_SYSTEM_PLL_AUDIO_LOSS_CNT_EN to add the lock_loss_count output.
module soc_system_pll_audio_supervisor
  import soc_system_pll_audio_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_restart,
  output logic       pll_rst,
  output logic       audio_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count
`ifdef SOC_SYSTEM_PLL_AUDIO_LOSS_CNT_EN
  ,
  output logic [15:0] lock_loss_count
`endif
);

  localparam int unsigned CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic lock_s;

  soc_system_pll_audio_sync u_lock_sync (
    .clk  (refclk),
    .srst (rst),
    .d    (pll_locked),
    .q    (lock_s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic             audio_rst_q, audio_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             loss_event;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    loss_event = 1'b0;
    if (soft_restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          // The cycle that sees lock counts as the first stable cycle.
          if (lock_s) begin
            state_d = (LOCK_STABLE_CYCLES > 1) ? STABLE : RUN;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_LIMIT) begin
              state_d = RESET_PLL;
              retry_d = retry_q + 4'd1;
            end else begin
              state_d = FAULT;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d    = RESET_PLL;
            cnt_d      = '0;
            retry_d    = '0;
            loss_event = 1'b1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they flip on the same edge as state_q.
  always_comb begin
    pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
    audio_rst_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      audio_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      audio_rst_q <= audio_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign audio_rst   = audio_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

`ifdef SOC_SYSTEM_PLL_AUDIO_LOSS_CNT_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_event && (loss_cnt_q != 16'hFFFF)) begin
      loss_cnt_d = loss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_count = loss_cnt_q;
`else
  logic unused_loss_event;
  assign unused_loss_event = loss_event;
`endif

endmodule

// File: doc/soc_system_pll_audio_supervisor.md
SOC_SYSTEM_PLL_AUDIO_SUPERVISOR -- requirements
Module: soc_system_pll_audio_supervisor

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16, giving the PLL reset pulse length in refclk cycles (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000000, giving the maximum wait for lock per attempt (20 ms at 50 MHz).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, giving the consecutive locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, giving the PLL reset retries allowed after the first attempt before fault (0..15).
REQ-005 SHALL have port refclk, input, 1 bit: the single clock, 50 MHz.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to refclk.
REQ-008 SHALL have port soft_restart, input, 1 bit: single-cycle request to re-run the bring-up sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: drives the audio PLL rst input.
REQ-010 SHALL have port audio_rst, output, 1 bit: active-high reset for logic clocked by the 18.432 MHz audio clock.
REQ-011 SHALL have port ready, output, 1 bit: high while the PLL is locked and stable.
REQ-012 SHALL have port fault, output, 1 bit: retries exhausted.
REQ-013 SHALL have port retry_count, output, 4 bits: retries consumed in the current bring-up.

Function
REQ-014 SHALL pass pll_locked through a two-flop synchronizer, giving lock_s with 2-cycle latency; all decisions SHALL use only lock_s.
REQ-015 SHALL implement the states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT.
REQ-016 SHALL, in RESET_PLL, hold pll_rst=1 for exactly RST_PULSE_CYCLES cycles and then move to WAIT_LOCK with the cycle counter cleared.
REQ-017 SHALL, in WAIT_LOCK, hold pll_rst=0 and:
- move to STABLE when lock_s=1;
- on counter reaching LOCK_TIMEOUT_CYCLES-1 with retry_count<MAX_RETRIES, increment retry_count and move to RESET_PLL;
- on that timeout with retry_count==MAX_RETRIES, move to FAULT.
REQ-018 SHALL, in STABLE, move to RUN after LOCK_STABLE_CYCLES consecutive cycles of lock_s=1; any lock_s=0 SHALL return to WAIT_LOCK with the timeout restarted and no retry charged.
REQ-019 SHALL, in RUN, drive audio_rst=0 and ready=1; lock_s=0 SHALL move to RESET_PLL and clear retry_count.
REQ-020 SHALL, in FAULT, hold pll_rst=1, audio_rst=1 and fault=1; the only exits SHALL be soft_restart or rst.
REQ-021 SHALL, on soft_restart in any state, move to RESET_PLL and clear retry_count and the counter; soft_restart SHALL take priority over all other events.
REQ-022 SHALL give lock priority over timeout when lock_s=1 and the timeout occur in the same WAIT_LOCK cycle.
REQ-023 SHALL register all outputs, decoded from the next state so they change in the same cycle as the state register:
- audio_rst=1 in every state except RUN;
- ready=1 only in RUN;
- pll_rst=1 only in RESET_PLL and FAULT.
REQ-024 SHALL size the cycle counter to $clog2 of the largest of the three cycle parameters, with no wrap inside any state.

Reset
REQ-025 SHALL, with rst high at a refclk edge, enter RESET_PLL with pll_rst=1, audio_rst=1, ready=0, fault=0, retry_count=0, counter=0 and synchronizer flops=0; rst asserted mid-operation SHALL behave the same.

Configuration
REQ-026 SHALL, when SOC_SYSTEM_PLL_AUDIO_LOSS_CNT_EN is defined, add output lock_loss_count (16 bits), reset to 0, incremented on each RUN-to-RESET_PLL transition caused by lock loss and saturating at 0xFFFF.
REQ-027 SHALL, when SOC_SYSTEM_PLL_AUDIO_LOSS_CNT_EN is undefined, omit that port and counter entirely, with all other behaviour identical.

Structure
REQ-028 SHALL place the state enum type and the default parameter constants in package soc_system_pll_audio_pkg.
REQ-029 SHALL implement the synchronizer as sub-module soc_system_pll_audio_sync (two flops, synchronous reset to 0).

Verification
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-030 SHALL cover normal bring-up: rst released, pll_locked raised 10 cycles after pll_rst falls and held -> ready=1 and audio_rst=0 exactly 2+8 cycles after the rise.
REQ-031 SHALL cover fault: pll_locked held 0 -> three 4-cycle pll_rst pulses separated by 32-cycle waits, retry_count 0->1->2, then fault=1 with pll_rst held high.
REQ-032 SHALL cover a lock glitch: pll_locked high for 5 cycles, low 1 cycle, then high -> no ready until 8 further consecutive cycles, and retry_count stays 0.
REQ-033 SHALL cover lock loss in RUN: pll_locked dropped -> ready=0 and audio_rst=1 3 cycles later, a new 4-cycle pll_rst pulse, and lock_loss_count=1 when the macro is defined.
REQ-034 SHALL cover soft_restart in FAULT and in RUN: soft_restart pulsed -> next cycle fault=0, retry_count=0, pll_rst=1 for 4 cycles.
REQ-035 SHALL cover simultaneous lock and timeout: lock_s rises in cycle 31 of WAIT_LOCK -> STABLE entered, with no retry charged.
